// File: rtl/hazard_detect.sv
// Pipeline hazard generator: load-use (cntlHzd), memory stall (memHzd), branch flush stretch (branchHzd).
// Latency: cntlHzd combinational, memHzd same cycle as miss, branchHzd one cycle after branch_taken.
// No backpressure: outputs feed the priority LUT directly; optional HZD_PERF_EN adds stall/flush counters.
module hazard_detect #(
  parameter int REG_W    = 4,
  parameter int BR_FLUSH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             icache_miss,
  input  logic             dcache_miss,
  input  logic             mem_ready,
  output logic             cntlHzd,
  output logic             memHzd,
  output logic             branchHzd
`ifdef HZD_PERF_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  localparam logic [2:0] BR_LOAD = 3'(BR_FLUSH);

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_WAIT = 2'd1;
  localparam logic [1:0] M_DONE = 2'd2;

  logic [1:0] mstate;
  logic [1:0] mstate_nxt;
  logic [2:0] br_cnt;
  logic       br_pend;
  logic       miss;
  logic       rs_hit;
  logic       rt_hit;

  assign miss = icache_miss | dcache_miss;

  // Load-use compare; register 0 is hardwired and never a producer.
  always_comb begin
    rs_hit  = id_uses_rs && (id_rs == ex_rd);
    rt_hit  = id_uses_rt && (id_rt == ex_rd);
    cntlHzd = ex_mem_read && (ex_rd != '0) && (rs_hit || rt_hit);
  end

  // Miss service sequencing: wait for fill, then one writeback cycle.
  always_comb begin
    mstate_nxt = mstate;
    case (mstate)
      M_IDLE:  if (miss) mstate_nxt = M_WAIT;
      M_WAIT:  if (mem_ready) mstate_nxt = M_DONE;
      M_DONE:  mstate_nxt = M_IDLE;
      default: mstate_nxt = M_IDLE;
    endcase
  end

  // A new miss stalls in the cycle it appears, before the FSM leaves idle.
  assign memHzd = (mstate != M_IDLE) || miss;

  // Memory FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) mstate <= M_IDLE;
    else        mstate <= mstate_nxt;
  end

  // Flush stretch: frozen under stall, a deferred branch restarts it once the stall clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt  <= 3'd0;
      br_pend <= 1'b0;
    end else if (memHzd) begin
      if (branch_taken) br_pend <= 1'b1;
    end else if (branch_taken || br_pend) begin
      br_cnt  <= BR_LOAD;
      br_pend <= 1'b0;
    end else if (br_cnt != 3'd0) begin
      br_cnt  <= br_cnt - 3'd1;
    end
  end

  assign branchHzd = (br_cnt != 3'd0);

`ifdef HZD_PERF_EN
  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if ((memHzd || cntlHzd) && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (branchHzd && (flush_cnt != 16'hFFFF))            flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_detect.sv
// Bench for hazard_detect: directed scenarios with literal expectations plus a per-cycle reference model.
// Latency: model predicts outputs for the current cycle, sampled on the falling edge.
// No backpressure: stimulus is driven freely one cycle at a time.
module tb_hazard_detect;

  localparam int BRF = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_mem_read;
  logic       branch_taken, icache_miss, dcache_miss, mem_ready;
  logic       cntlHzd, memHzd, branchHzd;
`ifdef HZD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_detect #(.REG_W(4), .BR_FLUSH(BRF)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .mem_ready(mem_ready),
    .cntlHzd(cntlHzd), .memHzd(memHzd), .branchHzd(branchHzd)
`ifdef HZD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ins();
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    branch_taken = 0; icache_miss = 0; dcache_miss = 0; mem_ready = 0;
  endtask

  // Reference model: stall phase (none / awaiting fill / writeback), remaining flush cycles, deferred branch.
  int fill_phase = 0;
  int flush_left = 0;
  bit deferred   = 0;
  bit model_ok   = 0;
  int stall_total = 0;
  int flush_total = 0;

  always @(negedge clk) begin : model
    logic e_cntl, e_mem, e_br, m;
    e_cntl = 1'b0;
    if (ex_mem_read && ex_rd != 4'd0) begin
      if (id_uses_rs && id_rs == ex_rd) e_cntl = 1'b1;
      if (id_uses_rt && id_rt == ex_rd) e_cntl = 1'b1;
    end
    m     = icache_miss | dcache_miss;
    e_mem = (fill_phase != 0) || m;
    e_br  = (flush_left > 0);
    chk("model_cntl", cntlHzd, e_cntl);
    if (model_ok) begin
      chk("model_mem", memHzd, e_mem);
      chk("model_br", branchHzd, e_br);
`ifdef HZD_PERF_EN
      chk16("model_stall_cnt", stall_cnt, 16'(stall_total));
      chk16("model_flush_cnt", flush_cnt, 16'(flush_total));
`endif
    end
    if (!rst_n) begin
      fill_phase = 0; flush_left = 0; deferred = 0;
      stall_total = 0; flush_total = 0; model_ok = 1;
    end else begin
      if (e_mem || e_cntl) stall_total = (stall_total < 65535) ? stall_total + 1 : 65535;
      if (e_br)            flush_total = (flush_total < 65535) ? flush_total + 1 : 65535;
      if (e_mem) begin
        if (branch_taken) deferred = 1;
      end else if (branch_taken || deferred) begin
        flush_left = BRF;
        deferred   = 0;
      end else if (flush_left > 0) begin
        flush_left = flush_left - 1;
      end
      if (fill_phase == 0) begin
        if (m) fill_phase = 1;
      end else if (fill_phase == 1) begin
        if (mem_ready) fill_phase = 2;
      end else begin
        fill_phase = 0;
      end
    end
  end

  typedef struct packed {
    logic       mr;
    logic [3:0] rd;
    logic [3:0] rs;
    logic       urs;
    logic [3:0] rt;
    logic       urt;
    logic       exp;
  } lu_t;

  lu_t lu [7];

  initial begin
    lu[0] = '{1'b1, 4'd5, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1};
    lu[1] = '{1'b1, 4'd0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0};
    lu[2] = '{1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0};
    lu[3] = '{1'b1, 4'd7, 4'd2, 1'b1, 4'd7, 1'b1, 1'b1};
    lu[4] = '{1'b1, 4'd7, 4'd7, 1'b0, 4'd2, 1'b1, 1'b0};
    lu[5] = '{1'b0, 4'd7, 4'd7, 1'b1, 4'd7, 1'b1, 1'b0};
    lu[6] = '{1'b1, 4'd9, 4'd9, 1'b1, 4'd9, 1'b0, 1'b1};

    clear_ins();
    rst_n = 0;
    // cntlHzd remains live while reset is held
    ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_cntl_live", cntlHzd, 1'b1);
      tick();
    end
    clear_ins();
    @(negedge clk);
    chk("rst_mem", memHzd, 1'b0);
    chk("rst_br", branchHzd, 1'b0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_mem", memHzd, 1'b0);
    chk("post_rst_br", branchHzd, 1'b0);
    chk("post_rst_cntl", cntlHzd, 1'b0);
    tick();

    // load-use vectors
    for (int i = 0; i < 7; i++) begin
      ex_mem_read = lu[i].mr; ex_rd = lu[i].rd;
      id_rs = lu[i].rs; id_uses_rs = lu[i].urs;
      id_rt = lu[i].rt; id_uses_rt = lu[i].urt;
      @(negedge clk);
      chk($sformatf("loaduse_%0d", i), cntlHzd, lu[i].exp);
      tick();
    end
    clear_ins();
    repeat (2) tick();

    // miss service: miss at 0, ready at 6, stall through 7
    for (int c = 0; c <= 8; c++) begin
      dcache_miss = (c <= 6);
      mem_ready   = (c == 6);
      @(negedge clk);
      chk($sformatf("miss_mem_c%0d", c), memHzd, (c <= 7));
      tick();
    end
    clear_ins();
    repeat (2) tick();

    // branch flush, two cycles
    for (int c = 0; c <= 3; c++) begin
      branch_taken = (c == 0);
      @(negedge clk);
      chk($sformatf("br_c%0d", c), branchHzd, (c >= 1 && c <= 2));
      tick();
    end
    clear_ins();
    repeat (2) tick();

    // branch during stall: deferred until the stall ends
    for (int c = 0; c <= 9; c++) begin
      icache_miss  = (c <= 4);
      branch_taken = (c == 2);
      mem_ready    = (c == 4);
      @(negedge clk);
      chk($sformatf("pend_br_c%0d", c), branchHzd, (c >= 7 && c <= 8));
      chk($sformatf("pend_mem_c%0d", c), memHzd, (c <= 5));
      tick();
    end
    clear_ins();
    repeat (2) tick();

    // back-to-back miss: no gap in memHzd
    for (int c = 0; c <= 7; c++) begin
      dcache_miss = (c <= 4);
      mem_ready   = (c == 2 || c == 5);
      @(negedge clk);
      chk($sformatf("b2b_mem_c%0d", c), memHzd, (c <= 6));
      tick();
    end
    clear_ins();
    repeat (2) tick();

    // reload during an active count does not accumulate
    for (int c = 0; c <= 4; c++) begin
      branch_taken = (c <= 1);
      @(negedge clk);
      chk($sformatf("reload_br_c%0d", c), branchHzd, (c >= 1 && c <= 3));
      tick();
    end
    clear_ins();
    repeat (2) tick();

    // reset mid-miss abandons the fill and any deferred branch
    for (int c = 0; c <= 7; c++) begin
      dcache_miss  = (c == 0);
      branch_taken = (c == 1);
      rst_n        = (c != 3);
      mem_ready    = (c == 5);
      @(negedge clk);
      chk($sformatf("rstmid_mem_c%0d", c), memHzd, (c <= 3));
      chk($sformatf("rstmid_br_c%0d", c), branchHzd, 1'b0);
      tick();
    end
    clear_ins();
    rst_n = 1;
    repeat (2) tick();

`ifdef HZD_PERF_EN
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int c = 0; c <= 16; c++) begin
      dcache_miss  = (c <= 8);
      mem_ready    = (c == 8);
      branch_taken = (c == 12);
      @(negedge clk);
      tick();
    end
    clear_ins();
    @(negedge clk);
    chk16("perf_stall", stall_cnt, 16'd10);
    chk16("perf_flush", flush_cnt, 16'd2);
    tick();
`endif

    // mixed traffic checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      icache_miss  = ($urandom_range(0, 9) == 0);
      dcache_miss  = ($urandom_range(0, 9) == 0);
      mem_ready    = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      ex_mem_read  = $urandom_range(0, 1);
      ex_rd        = 4'($urandom_range(0, 3));
      id_rs        = 4'($urandom_range(0, 3));
      id_rt        = 4'($urandom_range(0, 3));
      id_uses_rs   = $urandom_range(0, 1);
      id_uses_rt   = $urandom_range(0, 1);
      tick();
    end
    clear_ins();
    rst_n = 1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
